float_sample_dac_feeder: RTL and testbench

Sequences 32-bit float audio samples through the float-to-int converter wrapper and delivers saturated fixed-point samples to the audio DAC path.
- Accepts one float sample at a time over a valid/ready handshake.
- Pulses the converter's start, waits for its done, then saturates the 32-bit integer result to SAMPLE_WIDTH bits.
- Buffers converted samples in a small FIFO that the DAC side drains one sample per request.
- Sits between the effects datapath output and the codec serializer.

---
 rtl/float_sample_dac_feeder.sv | 166 ++++++++++++++++
 tb/tb_float_sample_dac_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_sample_dac_feeder.sv
// float_sample_dac_feeder
//
// Sequences IEEE-754 single-precision audio samples through the external
// float-to-int converter wrapper. The block saturates each 32-bit integer
// result to SAMPLE_WIDTH bits and buffers it in a small circular FIFO. The
// DAC side drains that FIFO one sample per request. The block sits between
// the effects datapath output and the codec serializer.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     float sample present on in_data
//   in_data      IEEE-754 single-precision sample
//   in_ready     sample accepted this cycle when in_valid is also high
//   conv_dataa   operand to converter (registered copy of accepted in_data)
//   conv_clk_en  one-cycle start pulse to converter
//   conv_result  signed 32-bit integer result from converter
//   conv_done    converter result valid (one-cycle pulse)
//   dac_req      DAC side requests one sample
//   dac_sample   last popped, saturated sample
//   dac_valid    one-cycle pulse when dac_sample was updated
//   fill_level   current FIFO occupancy
//   underrun     sticky: dac_req arrived while the FIFO was empty
//   timeout_err  sticky: converter never reported done
//   clear_err    clears both sticky flags (a same-cycle set wins)
module float_sample_dac_feeder #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  input  logic [31:0]                           in_data,
  output logic                                  in_ready,
  output logic [31:0]                           conv_dataa,
  output logic                                  conv_clk_en,
  input  logic [31:0]                           conv_result,
  input  logic                                  conv_done,
  input  logic                                  dac_req,
  output logic signed [SAMPLE_WIDTH-1:0]        dac_sample,
  output logic                                  dac_valid,
  output logic [$clog2(FIFO_DEPTH):0]           fill_level,
  output logic                                  underrun,
  output logic                                  timeout_err,
  input  logic                                  clear_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (SAMPLE_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (SAMPLE_WIDTH - 1));

  // The timer counts completed WAIT cycles. The abort is taken on the cycle
  // where TIMEOUT-1 cycles have already elapsed, which is the TIMEOUT-th WAIT cycle.
  localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

  function automatic logic signed [SAMPLE_WIDTH-1:0] sat_sample(input logic signed [31:0] v);
    logic signed [31:0] c;
    if (v > SAT_MAX)      c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else                  c = v;
    return c[SAMPLE_WIDTH-1:0];
  endfunction

  logic [1:0]                     state;
  logic [7:0]                     timer;
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic signed [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                           accept;
  logic                           push;
  logic                           pop;
  logic                           empty_req;
  logic                           abort;
  logic signed [SAMPLE_WIDTH-1:0] sat_p0;

  // A FIFO slot is reserved when a sample is accepted. Only one conversion is
  // ever in flight, so a push can never find the FIFO full.
  assign in_ready    = (state == S_IDLE) && (fill_level < LVL_W'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;
  assign conv_clk_en = (state == S_ISSUE);

  // conv_done is only meaningful while waiting; strays elsewhere are dropped.
  assign push      = (state == S_WAIT) && conv_done;
  assign abort     = (state == S_WAIT) && !conv_done && (timer == TMR_LAST);
  assign pop       = dac_req && (fill_level != '0);
  // No write-to-read bypass: an empty FIFO underruns even while a push lands.
  assign empty_req = dac_req && (fill_level == '0);
  assign sat_p0    = sat_sample($signed(conv_result));

  // Conversion sequencing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      conv_dataa <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            conv_dataa <= in_data;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (push || abort) state <= S_IDLE;
          else               timer <= timer + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sample storage (data only, no reset needed)
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= sat_p0;
  end

  // FIFO pointers, occupancy and output stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      dac_sample <= '0;
      dac_valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        dac_sample <= mem[rd_ptr];
      end
      dac_valid <= pop;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + LVL_W'(1);
        2'b01:   fill_level <= fill_level - LVL_W'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Sticky error flags; a set event outranks clear_err
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underrun    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (empty_req)      underrun <= 1'b1;
      else if (clear_err) underrun <= 1'b0;
      if (abort)          timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_float_sample_dac_feeder.sv
module tb_float_sample_dac_feeder;
  localparam int SW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic [31:0]   conv_dataa;
  logic          conv_clk_en;
  logic [31:0]   conv_result;
  logic          conv_done;
  logic          dac_req;
  logic [SW-1:0] dac_sample;
  logic          dac_valid;
  logic [2:0]    fill_level;
  logic          underrun;
  logic          timeout_err;
  logic          clear_err;

  float_sample_dac_feeder #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .conv_dataa(conv_dataa), .conv_clk_en(conv_clk_en),
    .conv_result(conv_result), .conv_done(conv_done), .dac_req(dac_req),
    .dac_sample(dac_sample), .dac_valid(dac_valid), .fill_level(fill_level),
    .underrun(underrun), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: a queue of saturated samples plus a busy flag
  // holding the edge index of the accept that started the conversion.
  logic [SW-1:0] m_q[$];
  bit            m_busy;
  int            m_acc;
  logic [31:0]   m_dataa;
  logic [SW-1:0] m_sample;
  bit            m_dvalid, m_under, m_tmo;
  int            m_accepts;
  int            plan_lat, next_lat;
  logic [31:0]   plan_res, next_res;
  bit            force_stray, rand_stray;
  int            n;
  int            checks, errors;

  function automatic logic [SW-1:0] sat_ref(input logic [31:0] r);
    longint v, lim;
    v   = longint'($signed(r));
    lim = longint'(1) <<< (SW - 1);
    if (v > lim - 1)   v = lim - 1;
    else if (v < -lim) v = -lim;
    return v[SW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("in_ready",    32'(in_ready),    32'(!m_busy && m_q.size() < DEPTH));
    chk("conv_clk_en", 32'(conv_clk_en), 32'(m_busy && n == m_acc));
    chk("conv_dataa",  conv_dataa,       m_dataa);
    chk("dac_valid",   32'(dac_valid),   32'(m_dvalid));
    chk("dac_sample",  32'(dac_sample),  32'(m_sample));
    chk("fill_level",  32'(fill_level),  32'(m_q.size()));
    chk("underrun",    32'(underrun),    32'(m_under));
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_dataa = '0; m_sample = '0; m_dvalid = 0; m_under = 0; m_tmo = 0;
  endtask

  // Called at a negedge with in_valid/in_data/dac_req/clear_err already set.
  // Drives the converter side, advances the model over the next rising edge
  // and compares at the following falling edge.
  task automatic step();
    int e, k;
    bit in_wait, ready, set_u, set_t;
    e       = n + 1;
    in_wait = m_busy && (e >= m_acc + 2);
    k       = e - m_acc - 1;
    if (in_wait && k == plan_lat) begin
      conv_done = 1'b1; conv_result = plan_res;
    end else if (!in_wait && (force_stray || (rand_stray && $urandom_range(0, 7) == 0))) begin
      conv_done = 1'b1; conv_result = $urandom;
    end else begin
      conv_done = 1'b0; conv_result = $urandom;
    end
    force_stray = 0;
    ready    = !m_busy && (m_q.size() < DEPTH);
    set_u    = 0;
    set_t    = 0;
    m_dvalid = 0;
    if (dac_req) begin
      if (m_q.size() > 0) begin m_sample = m_q.pop_front(); m_dvalid = 1; end
      else set_u = 1;
    end
    if (in_wait) begin
      if (conv_done) begin m_q.push_back(sat_ref(conv_result)); m_busy = 0; end
      else if (k == TMO) begin set_t = 1; m_busy = 0; end
    end
    if (in_valid && ready) begin
      m_busy = 1; m_acc = e; m_dataa = in_data; m_accepts++;
      plan_lat = next_lat; plan_res = next_res;
    end
    if (set_u) m_under = 1; else if (clear_err) m_under = 0;
    if (set_t) m_tmo = 1;   else if (clear_err) m_tmo = 0;
    @(posedge clock);
    n++;
    @(negedge clock);
    check_model();
  endtask

  task automatic wait_accept();
    int start;
    start = m_accepts;
    for (int i = 0; i < 40 && m_accepts == start; i++) step();
    chk("accept_bound", 32'(m_accepts - start), 32'd1);
  endtask

  task automatic convert_one(input logic [31:0] res);
    next_lat = 8; next_res = res; in_valid = 1'b1; in_data = $urandom;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    dac_req = 1'b1;
    step();
    dac_req = 1'b0;
  endtask

  task automatic async_reset_check();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_fill",      32'(fill_level),  32'd0);
    chk("rst_in_ready",  32'(in_ready),    32'd1);
    chk("rst_dataa",     conv_dataa,       32'd0);
    chk("rst_clk_en",    32'(conv_clk_en), 32'd0);
    chk("rst_sample",    32'(dac_sample),  32'd0);
    chk("rst_dvalid",    32'(dac_valid),   32'd0);
    chk("rst_underrun",  32'(underrun),    32'd0);
    chk("rst_timeout",   32'(timeout_err), 32'd0);
    @(posedge clock);
    n++;
    @(negedge clock);
    reset_n = 1'b1;
    check_model();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bvals[6];
    int tmp;
    bvals = '{32767, 32768, -32768, -32769, 0, -1};
    checks = 0; errors = 0; n = 0; m_acc = -100; m_accepts = 0;
    plan_lat = 8; next_lat = 8; plan_res = '0; next_res = '0;
    force_stray = 0; rand_stray = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; dac_req = 1'b0;
    clear_err = 1'b0; conv_done = 1'b0; conv_result = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_model();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    // Single 1000.0 conversion and pop
    in_data = 32'h447A0000; next_lat = 8; next_res = 32'd1000; in_valid = 1'b1;
    step();
    chk("issue_pulse", 32'(conv_clk_en), 32'd1);
    chk("issue_dataa", conv_dataa, 32'h447A0000);
    chk("ready_drop",  32'(in_ready), 32'd0);
    in_valid = 1'b0;
    step();
    chk("issue_end", 32'(conv_clk_en), 32'd0);
    repeat (7) step();
    chk("fill_pre_done", 32'(fill_level), 32'd0);
    step();
    chk("fill_post_done", 32'(fill_level), 32'd1);
    chk("ready_return",   32'(in_ready),   32'd1);
    dac_req = 1'b1;
    step();
    dac_req = 1'b0;
    chk("pop_1000",  32'(dac_sample), 32'd1000);
    chk("pop_valid", 32'(dac_valid),  32'd1);
    chk("pop_fill",  32'(fill_level), 32'd0);
    step();
    chk("valid_pulse", 32'(dac_valid), 32'd0);

    // Saturation
    convert_one(32'd70000);
    chk("sat_pos", 32'(dac_sample), 32'h7FFF);
    convert_one(-32'sd70000);
    chk("sat_neg", 32'(dac_sample), 32'h8000);
    convert_one(-32'sd5);
    chk("neg_five", 32'(dac_sample), 32'hFFFB);
    convert_one(32'd32768);
    chk("sat_edge_pos", 32'(dac_sample), 32'h7FFF);
    convert_one(-32'sd32768);
    chk("edge_neg", 32'(dac_sample), 32'h8000);

    // Five back-to-back inputs, FIFO fills, fifth stalls
    for (int i = 0; i < 4; i++) begin
      next_lat = 8; next_res = 32'(11 * (i + 1)); in_valid = 1'b1; in_data = $urandom;
      wait_accept();
    end
    next_res = 32'd55;
    for (int i = 0; i < 20 && !(!m_busy && m_q.size() == DEPTH); i++) step();
    repeat (3) step();
    chk("full_stall_ready", 32'(in_ready),   32'd0);
    chk("full_fill",        32'(fill_level), 32'd4);
    dac_req = 1'b1;
    step();
    dac_req = 1'b0;
    chk("drain_11",     32'(dac_sample), 32'd11);
    chk("drain_fill_3", 32'(fill_level), 32'd3);
    wait_accept();
    in_valid = 1'b0;
    repeat (10) step();
    chk("refill_4", 32'(fill_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      dac_req = 1'b1;
      step();
      chk("drain_order", 32'(dac_sample), 32'(22 + 11 * i));
    end
    dac_req = 1'b0;

    // Underrun and clear-versus-set priority
    dac_req = 1'b1;
    step();
    chk("underrun_set",  32'(underrun),   32'd1);
    chk("underrun_nov",  32'(dac_valid),  32'd0);
    chk("underrun_hold", 32'(dac_sample), 32'd55);
    clear_err = 1'b1;
    step();
    chk("underrun_set_wins", 32'(underrun), 32'd1);
    dac_req = 1'b0;
    step();
    chk("underrun_cleared", 32'(underrun), 32'd0);
    clear_err = 1'b0;

    // Converter timeout and a stray done afterwards
    next_lat = 255; next_res = 32'd77; in_valid = 1'b1; in_data = $urandom;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    chk("tmo_not_yet", 32'(timeout_err), 32'd0);
    step();
    chk("tmo_set",   32'(timeout_err), 32'd1);
    chk("tmo_ready", 32'(in_ready),    32'd1);
    chk("tmo_fill",  32'(fill_level),  32'd0);
    force_stray = 1;
    step();
    chk("stray_ignored", 32'(fill_level), 32'd0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("tmo_cleared", 32'(timeout_err), 32'd0);

    // Async reset mid-WAIT with two samples buffered, then a late done
    dac_req = 1'b1;
    step();
    dac_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_lat = 8; next_res = 32'(7 + i); in_valid = 1'b1; in_data = $urandom;
      step();
      in_valid = 1'b0;
      repeat (9) step();
    end
    next_lat = 8; next_res = 32'd9; in_valid = 1'b1; in_data = 32'h3F800000;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("pre_reset_fill",  32'(fill_level), 32'd2);
    chk("pre_reset_under", 32'(underrun),   32'd1);
    async_reset_check();
    force_stray = 1;
    step();
    chk("late_done_ignored", 32'(fill_level), 32'd0);
    step();

    // Randomized phase
    rand_stray = 1;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      dac_req   = ($urandom_range(0, 3) == 0);
      clear_err = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0, 1:    next_lat = $urandom_range(1, TMO);
        2:       next_lat = TMO + 10;
        default: next_lat = 8;
      endcase
      case ($urandom_range(0, 3))
        0: next_res = $urandom;
        1: begin tmp = int'($urandom_range(0, 80000)) - 40000; next_res = 32'(tmp); end
        2: next_res = 32'(bvals[$urandom_range(0, 5)]);
        default: begin tmp = int'($urandom_range(0, 200)) - 100; next_res = 32'(tmp); end
      endcase
      if (i == 1500) async_reset_check();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
